// File: rtl/aes_pkg.sv
// Shared AES definitions: FIPS-197 S-box tables, engine state encoding and
// the LANES legality check used at elaboration.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Lane count must divide the 16-byte state into a power-of-two beat count.
    function automatic logic lanes_ok(input int unsigned lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte forward/inverse AES S-box, pure table lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] x,
    input  logic       inv,
    output logic [7:0] y
);

    assign y = inv ? INV_SBOX[x] : SBOX[x];

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// SubBytes/InvSubBytes engine: LANES S-boxes swept over the 16 state bytes
// in 16/LANES beats, with valid/ready on both sides.
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned BEATS = 16 / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (!lanes_ok(LANES)) begin : g_lanes_chk
        $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    state_t           state;
    state_t           state_nxt;
    logic [BW-1:0]    beat;
    logic             mode;
    logic [15:0][7:0] src;
    logic [15:0][7:0] src_upd;
    logic [3:0]       base;
    logic             accept;
    logic             last;
    logic [7:0]       lane_x [LANES];
    logic [7:0]       lane_y [LANES];

    assign base = 4'(32'(beat) * LANES);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox u_sbox (
            .x   (lane_x[l]),
            .inv (mode),
            .y   (lane_y[l])
        );
    end

    // Current beat's bytes fed to the lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_x[l] = src[base + 4'(l)];
        end
    end

    // Working state with this beat's substituted bytes merged in.
    always_comb begin
        src_upd = src;
        for (int l = 0; l < LANES; l++) begin
            src_upd[base + 4'(l)] = lane_y[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (beat == LAST_BEAT) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bytes are substituted in place; out_data only updates on the final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat     <= '0;
            mode     <= 1'b0;
            src      <= '0;
            out_data <= '0;
        end else begin
            if (accept) begin
                src  <= in_data;
                mode <= in_inv;
                beat <= '0;
            end
            if (state == BUSY) begin
                src <= src_upd;
                if (!last) begin
                    beat <= beat + BW'(1);
                end
            end
            if (last) begin
                out_data <= src_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Self-checking bench for aes_sub_bytes_seq at LANES = 1, 4 and 16 against a
// GF(2^8) arithmetic S-box model.
module tb_aes_sub_bytes_seq;

    localparam int NI = 3;

    logic         clk;
    logic         rst       [NI];
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [127:0] in_data   [NI];
    logic         in_inv    [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] out_data  [NI];
    logic         busy      [NI];

    int n_chk;
    int n_fail;

    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    typedef struct {
        logic [127:0] data;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [7];

    function automatic int lanes_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 16;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_sub_bytes_seq #(.LANES((g == 0) ? 1 : (g == 1) ? 4 : 16)) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(x, 8'(c)) == 8'h01) b = 8'(c);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = inv ? m_inv[d[8*i +: 8]] : m_fwd[d[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept one state and wait for out_valid; optional noise on ignored inputs.
    task automatic start_block(input int k, input logic [127:0] d, input logic inv,
                               input bit noise, output logic [127:0] res, output int lat);
        int t;
        t = 0;
        while (in_ready[k] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", 128'(in_ready[k]), 128'd1);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_inv[k]   = inv;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_data[k]  = ~d;
        in_inv[k]   = ~inv;
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 100) begin
            if (noise) begin
                in_valid[k]  = 1'($urandom);
                in_data[k]   = {$urandom, $urandom, $urandom, $urandom};
                in_inv[k]    = 1'($urandom);
                out_ready[k] = 1'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        if (lat >= 100) chk("result_timeout", 128'(out_valid[k]), 128'd1);
        res = out_data[k];
    endtask

    task automatic consume(input int k);
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        chk("out_valid_drop", 128'(out_valid[k]), 128'd0);
        chk("in_ready_back", 128'(in_ready[k]), 128'd1);
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] d;
        logic [127:0] e;
        logic [127:0] r1;
        logic         inv;
        int           lat;
        int           k;

        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < NI; i++) begin
            rst[i]       = 1'b1;
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_inv[i]    = 1'b0;
            out_ready[i] = 1'b0;
        end

        vt[0] = '{128'h0, 1'b0, {16{8'h63}}};
        vt[1] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
        vt[2] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vt[3] = '{{16{8'h63}}, 1'b1, 128'h0};
        vt[4] = '{{16{8'hed}}, 1'b1, {16{8'h53}}};
        vt[5] = '{{16{8'h16}}, 1'b1, {16{8'hff}}};
        vt[6] = '{{16{8'h53}}, 1'b0, {16{8'hed}}};

        for (int x = 0; x < 256; x++) m_fwd[x] = sbox_ref(8'(x));
        for (int x = 0; x < 256; x++) m_inv[m_fwd[x]] = 8'(x);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;

        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_in_ready_L%0d", lanes_of(i)), 128'(in_ready[i]), 128'd1);
            chk($sformatf("reset_out_valid_L%0d", lanes_of(i)), 128'(out_valid[i]), 128'd0);
            chk($sformatf("reset_out_data_L%0d", lanes_of(i)), out_data[i], 128'd0);
            chk($sformatf("reset_busy_L%0d", lanes_of(i)), 128'(busy[i]), 128'd0);
        end

        // Directed vector table on every lane configuration.
        for (int i = 0; i < NI; i++) begin
            for (int v = 0; v < 7; v++) begin
                start_block(i, vt[v].data, vt[v].inv, 1'b0, res, lat);
                chk($sformatf("vec%0d_L%0d", v, lanes_of(i)), res, vt[v].exp);
                chk($sformatf("lat%0d_L%0d", v, lanes_of(i)), 128'(lat), 128'(16 / lanes_of(i)));
                consume(i);
            end
        end

        // One 8'h16 byte at each position among 8'h63 bytes, inverse mode.
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 16; p++) begin
                d = {16{8'h63}};
                e = 128'h0;
                d[8*p +: 8] = 8'h16;
                e[8*p +: 8] = 8'hff;
                start_block(i, d, 1'b1, 1'b0, res, lat);
                chk($sformatf("pos%0d_L%0d", p, lanes_of(i)), res, e);
                consume(i);
            end
        end

        // Backpressure with garbage on the input side.
        start_block(1, vt[1].data, 1'b0, 1'b0, res, lat);
        for (int c = 0; c < 10; c++) begin
            in_valid[1] = 1'b1;
            in_inv[1]   = ~in_inv[1];
            in_data[1]  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid[1]), 128'd1);
            chk("bp_out_data", out_data[1], vt[1].exp);
            chk("bp_in_ready", 128'(in_ready[1]), 128'd0);
            chk("bp_busy", 128'(busy[1]), 128'd1);
        end
        in_valid[1] = 1'b0;
        consume(1);
        chk("hold_after_consume", out_data[1], vt[1].exp);
        chk("busy_after_consume", 128'(busy[1]), 128'd0);

        // Reset at beat 7 of a LANES=1 block.
        in_valid[0] = 1'b1;
        in_data[0]  = vt[1].data;
        in_inv[0]   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        chk("midrst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("midrst_out_data", out_data[0], 128'd0);
        chk("midrst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("midrst_busy", 128'(busy[0]), 128'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_output", 128'(out_valid[0]), 128'd0);
        start_block(0, {16{8'h53}}, 1'b0, 1'b0, res, lat);
        chk("midrst_next_data", res, {16{8'hed}});
        chk("midrst_next_lat", 128'(lat), 128'd16);
        consume(0);

        // Random soak across configurations.
        for (int n = 0; n < 1000; n++) begin
            k   = n % NI;
            d   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_block(k, d, inv, 1'b1, res, lat);
            chk($sformatf("soak%0d_L%0d", n, lanes_of(k)), res, sub_model(d, inv));
            chk($sformatf("soak_lat%0d", n), 128'(lat), 128'(16 / lanes_of(k)));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                @(negedge clk);
            end
            consume(k);
        end

        // Exhaustive S^-1(S(x)) = x over all 256 byte values.
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * b + i);
            start_block(2, d, 1'b0, 1'b0, r1, lat);
            chk($sformatf("rt_fwd%0d", b), r1, sub_model(d, 1'b0));
            consume(2);
            start_block(2, r1, 1'b1, 1'b0, res, lat);
            chk($sformatf("rt_inv%0d", b), res, d);
            consume(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
